// File: rtl/ram16x4_seq.sv
// Access sequencer for a 16x4 ECL register-file RAM. Accepts one read or
// write request at a time and produces fully registered enable, address,
// data and write-strobe waveforms with programmable setup, strobe width,
// hold and read-access times. Read results are captured into rsp_data.
module ram16x4_seq #(
   parameter int SETUP_CYC = 1,
   parameter int WIDTH_CYC = 1,
   parameter int HOLD_CYC  = 1,
   parameter int READ_CYC  = 1
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [3:0] req_addr,
   input  logic [3:0] req_data,
   output logic       rsp_valid,
   output logic [3:0] rsp_data,
   output logic       busy,
   output logic       a0,
   output logic       a1,
   output logic       a2,
   output logic       a3,
   output logic       d0,
   output logic       d1,
   output logic       d2,
   output logic       d3,
   output logic       nen,
   output logic       nwrite,
   input  logic       q0,
   input  logic       q1,
   input  logic       q2,
   input  logic       q3
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WSETUP  = 3'd1,
      WSTROBE = 3'd2,
      WHOLD   = 3'd3,
      RWAIT   = 3'd4
   } state_e;

   // Counter load values: a phase of N cycles counts N-1 down to 0.
   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] WIDTH_LD = 4'(WIDTH_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
   localparam logic [3:0] READ_LD  = 4'(READ_CYC - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic       nen_q, nen_d;
   logic       nwrite_q, nwrite_d;
   logic [3:0] addr_q, addr_d;
   logic [3:0] data_q, data_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [3:0] rsp_data_q, rsp_data_d;

   logic       accept;
   logic       phase_done;

   assign accept     = req_valid && (state_q == IDLE);
   assign phase_done = (cnt_q == 4'd0);

   // State and phase counter registers.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: each phase lasts its programmed cycle count, then advances.
   // NOTE: defaults are assigned first so no path leaves a variable
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = req_write ? WSETUP : RWAIT;
               cnt_d   = req_write ? SETUP_LD : READ_LD;
            end
         end
         WSETUP: begin
            if (phase_done) begin
               state_d = WSTROBE;
               cnt_d   = WIDTH_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         WSTROBE: begin
            if (phase_done) begin
               state_d = WHOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         WHOLD: begin
            if (phase_done) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RWAIT: begin
            if (phase_done) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Output decode: RAM pin levels follow the upcoming state so the pins
   // themselves can be driven straight from flops with no glitches.
   always_comb begin
      nen_d       = (state_d == IDLE);
      nwrite_d    = (state_d != WSTROBE);
      addr_d      = addr_q;
      data_d      = data_q;
      rsp_valid_d = (state_q == RWAIT) && phase_done;
      rsp_data_d  = rsp_data_q;
      if (accept) begin
         addr_d = req_addr;
         // Reads leave the data pins at their last written value.
         if (req_write) begin
            data_d = req_data;
         end
      end
      if (rsp_valid_d) begin
         rsp_data_d = {q0, q1, q2, q3};
      end
   end

   // Output registers: every RAM-side pin and the response come from here.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         nen_q       <= 1'b1;
         nwrite_q    <= 1'b1;
         addr_q      <= 4'd0;
         data_q      <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 4'd0;
      end else begin
         nen_q       <= nen_d;
         nwrite_q    <= nwrite_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign nen       = nen_q;
   assign nwrite    = nwrite_q;
   assign a0        = addr_q[3];
   assign a1        = addr_q[2];
   assign a2        = addr_q[1];
   assign a3        = addr_q[0];
   assign d0        = data_q[3];
   assign d1        = data_q[2];
   assign d2        = data_q[1];
   assign d3        = data_q[0];

endmodule

// File: tb/tb_ram16x4_seq.sv
// Directed bench for ram16x4_seq. Instance A runs 1/1/1 write timing with a
// two-cycle read; instance B runs 2/3/2 write timing. Each instance drives a
// behavioural 16x4 RAM that commits on the trailing edge of its write enable.
module tb_ram16x4_seq;

   logic clk;
   logic nrst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errs    = 0;

   // ---------------- instance A ----------------
   logic       req_valid_a, req_ready_a, req_write_a;
   logic [3:0] req_addr_a, req_data_a, rsp_data_a;
   logic       rsp_valid_a, busy_a, nen_a, nwrite_a;
   logic       a0_a, a1_a, a2_a, a3_a, d0_a, d1_a, d2_a, d3_a;
   logic       q0_a, q1_a, q2_a, q3_a;

   ram16x4_seq #(.SETUP_CYC(1), .WIDTH_CYC(1), .HOLD_CYC(1), .READ_CYC(2)) dut_a (
      .clk(clk), .nrst(nrst),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
      .req_addr(req_addr_a), .req_data(req_data_a),
      .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a),
      .a0(a0_a), .a1(a1_a), .a2(a2_a), .a3(a3_a),
      .d0(d0_a), .d1(d1_a), .d2(d2_a), .d3(d3_a),
      .nen(nen_a), .nwrite(nwrite_a),
      .q0(q0_a), .q1(q1_a), .q2(q2_a), .q3(q3_a)
   );

   // ---------------- instance B ----------------
   logic       req_valid_b, req_ready_b, req_write_b;
   logic [3:0] req_addr_b, req_data_b, rsp_data_b;
   logic       rsp_valid_b, busy_b, nen_b, nwrite_b;
   logic       a0_b, a1_b, a2_b, a3_b, d0_b, d1_b, d2_b, d3_b;
   logic       q0_b, q1_b, q2_b, q3_b;

   ram16x4_seq #(.SETUP_CYC(2), .WIDTH_CYC(3), .HOLD_CYC(2), .READ_CYC(1)) dut_b (
      .clk(clk), .nrst(nrst),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
      .req_addr(req_addr_b), .req_data(req_data_b),
      .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b),
      .a0(a0_b), .a1(a1_b), .a2(a2_b), .a3(a3_b),
      .d0(d0_b), .d1(d1_b), .d2(d2_b), .d3(d3_b),
      .nen(nen_b), .nwrite(nwrite_b),
      .q0(q0_b), .q1(q1_b), .q2(q2_b), .q3(q3_b)
   );

   // ---------------- RAM models ----------------
   logic [3:0] apins_a, dpins_a, apins_b, dpins_b;
   assign apins_a = {a0_a, a1_a, a2_a, a3_a};
   assign dpins_a = {d0_a, d1_a, d2_a, d3_a};
   assign apins_b = {a0_b, a1_b, a2_b, a3_b};
   assign dpins_b = {d0_b, d1_b, d2_b, d3_b};

   logic [3:0] mem_a [16];
   logic [3:0] mem_b [16];
   logic [3:0] lat_addr_a, lat_data_a, lat_addr_b, lat_data_b;
   logic       we_a, we_b;
   int         commits_a = 0;
   int         commits_b = 0;
   int         nen_falls_b = 0;

   assign we_a = !nen_a && !nwrite_a;
   assign we_b = !nen_b && !nwrite_b;

   // The RAM latches address/data while its write enable is active and
   // commits them when the enable falls (including a reset-induced fall).
   always @(negedge clk) begin
      if (we_a) begin
         lat_addr_a <= apins_a;
         lat_data_a <= dpins_a;
      end
      if (we_b) begin
         lat_addr_b <= apins_b;
         lat_data_b <= dpins_b;
      end
   end

   always @(negedge we_a) begin
      mem_a[lat_addr_a] = lat_data_a;
      commits_a++;
   end

   always @(negedge we_b) begin
      mem_b[lat_addr_b] = lat_data_b;
      commits_b++;
   end

   always @(negedge nen_b) nen_falls_b++;

   assign {q0_a, q1_a, q2_a, q3_a} = nen_a ? 4'h0 : mem_a[apins_a];
   assign {q0_b, q1_b, q2_b, q3_b} = nen_b ? 4'h0 : mem_b[apins_b];

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle_a(input string name);
      int n = 0;
      while (busy_a && n < 50) begin
         step();
         n++;
      end
      vectors++;
      if (busy_a !== 1'b0) begin
         $display("FAIL %s: sequencer still busy after %0d cycles (busy=%b, want 0)", name, n, busy_a);
         errs++;
      end
   endtask

   task automatic do_write_a(input logic [3:0] addr, input logic [3:0] data);
      req_valid_a = 1'b1;
      req_write_a = 1'b1;
      req_addr_a  = addr;
      req_data_a  = data;
      step();
      req_valid_a = 1'b0;
      wait_idle_a("preload_write");
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      nrst = 1'b1;
      #1 nrst = 1'b0;
      #1;
      vectors++;
      if ({nen_a, nwrite_a, busy_a, req_ready_a, rsp_valid_a} !== 5'b11010) begin
         $display("FAIL reset_ctrl: nen/nwrite/busy/ready/rsp_valid=%b want 11010",
                  {nen_a, nwrite_a, busy_a, req_ready_a, rsp_valid_a});
         errs++;
      end
      vectors++;
      if ({apins_a, dpins_a, rsp_data_a} !== 12'h000) begin
         $display("FAIL reset_data: a=%h d=%h rsp=%h want 0 0 0", apins_a, dpins_a, rsp_data_a);
         errs++;
      end
      #10 nrst = 1'b1;
      step();
   endtask

   task automatic test_write();
      int c0 = commits_a;
      req_valid_a = 1'b1;
      req_write_a = 1'b1;
      req_addr_a  = 4'hA;
      req_data_a  = 4'h5;
      step();
      req_valid_a = 1'b0;
      vectors++;
      if ({nen_a, nwrite_a, busy_a, apins_a, dpins_a} !== {3'b011, 4'b1010, 4'b0101}) begin
         $display("FAIL write_setup: nen=%b nwrite=%b busy=%b a=%b d=%b want 0 1 1 1010 0101",
                  nen_a, nwrite_a, busy_a, apins_a, dpins_a);
         errs++;
      end
      step();
      vectors++;
      if ({nen_a, nwrite_a, apins_a, dpins_a} !== {2'b00, 4'b1010, 4'b0101}) begin
         $display("FAIL write_strobe: nen=%b nwrite=%b a=%b d=%b want 0 0 1010 0101",
                  nen_a, nwrite_a, apins_a, dpins_a);
         errs++;
      end
      step();
      vectors++;
      if ({nen_a, nwrite_a, apins_a, dpins_a} !== {2'b01, 4'b1010, 4'b0101}) begin
         $display("FAIL write_hold: nen=%b nwrite=%b a=%b d=%b want 0 1 1010 0101",
                  nen_a, nwrite_a, apins_a, dpins_a);
         errs++;
      end
      step();
      vectors++;
      if ({nen_a, nwrite_a, req_ready_a, rsp_valid_a} !== 4'b1110) begin
         $display("FAIL write_done: nen/nwrite/ready/rsp_valid=%b want 1110",
                  {nen_a, nwrite_a, req_ready_a, rsp_valid_a});
         errs++;
      end
      vectors++;
      if (mem_a[4'hA] !== 4'h5 || commits_a - c0 != 1) begin
         $display("FAIL write_commit: word[A]=%h commits=%0d want 5 1", mem_a[4'hA], commits_a - c0);
         errs++;
      end
   endtask

   task automatic test_read();
      req_valid_a = 1'b1;
      req_write_a = 1'b0;
      req_addr_a  = 4'hA;
      step();
      req_valid_a = 1'b0;
      vectors++;
      if ({nen_a, nwrite_a, rsp_valid_a, apins_a} !== {3'b010, 4'b1010}) begin
         $display("FAIL read_c1: nen=%b nwrite=%b rsp_valid=%b a=%b want 0 1 0 1010",
                  nen_a, nwrite_a, rsp_valid_a, apins_a);
         errs++;
      end
      step();
      vectors++;
      if (rsp_valid_a !== 1'b0 || busy_a !== 1'b1) begin
         $display("FAIL read_c2: rsp_valid=%b busy=%b want 0 1", rsp_valid_a, busy_a);
         errs++;
      end
      step();
      vectors++;
      if ({rsp_valid_a, req_ready_a, rsp_data_a} !== {2'b11, 4'h5}) begin
         $display("FAIL read_rsp: rsp_valid=%b ready=%b data=%h want 1 1 5",
                  rsp_valid_a, req_ready_a, rsp_data_a);
         errs++;
      end
      step();
      vectors++;
      if ({rsp_valid_a, rsp_data_a} !== {1'b0, 4'h5}) begin
         $display("FAIL read_after: rsp_valid=%b data=%h want 0 5", rsp_valid_a, rsp_data_a);
         errs++;
      end
   endtask

   task automatic test_back_to_back();
      do_write_a(4'h0, 4'h3);
      do_write_a(4'hF, 4'hC);
      req_valid_a = 1'b1;
      req_write_a = 1'b0;
      req_addr_a  = 4'h0;
      step();
      req_addr_a = 4'hF;
      step();
      vectors++;
      if (rsp_valid_a !== 1'b0) begin
         $display("FAIL b2b_first_wait: rsp_valid=%b want 0", rsp_valid_a);
         errs++;
      end
      step();
      vectors++;
      if ({rsp_valid_a, req_ready_a, rsp_data_a} !== {2'b11, 4'h3}) begin
         $display("FAIL b2b_first_rsp: rsp_valid=%b ready=%b data=%h want 1 1 3",
                  rsp_valid_a, req_ready_a, rsp_data_a);
         errs++;
      end
      step();
      req_valid_a = 1'b0;
      vectors++;
      if ({busy_a, rsp_valid_a, apins_a} !== {2'b10, 4'hF}) begin
         $display("FAIL b2b_second_accept: busy=%b rsp_valid=%b a=%h want 1 0 f",
                  busy_a, rsp_valid_a, apins_a);
         errs++;
      end
      step();
      step();
      vectors++;
      if ({rsp_valid_a, rsp_data_a} !== {1'b1, 4'hC}) begin
         $display("FAIL b2b_second_rsp: rsp_valid=%b data=%h want 1 c", rsp_valid_a, rsp_data_a);
         errs++;
      end
      step();
   endtask

   task automatic test_timing_busy();
      logic [0:6] exp_nw;
      int c0 = commits_b;
      int f0 = nen_falls_b;
      exp_nw = 7'b1100011;
      req_valid_b = 1'b1;
      req_write_b = 1'b1;
      req_addr_b  = 4'h6;
      req_data_b  = 4'h9;
      step();
      for (int i = 0; i < 7; i++) begin
         vectors++;
         if ({nen_b, nwrite_b, apins_b, dpins_b} !== {1'b0, exp_nw[i], 4'h6, 4'h9}) begin
            $display("FAIL timing_c%0d: nen=%b nwrite=%b a=%h d=%h want 0 %b 6 9",
                     i, nen_b, nwrite_b, apins_b, dpins_b, exp_nw[i]);
            errs++;
         end
         if (i == 0) begin
            req_addr_b = 4'h1;
            req_data_b = 4'hF;
         end
         if (i == 4) req_valid_b = 1'b0;
         step();
      end
      vectors++;
      if ({nen_b, nwrite_b, busy_b} !== 3'b110) begin
         $display("FAIL timing_done: nen/nwrite/busy=%b want 110", {nen_b, nwrite_b, busy_b});
         errs++;
      end
      step();
      step();
      vectors++;
      if (nen_falls_b - f0 != 1 || commits_b - c0 != 1 || mem_b[4'h6] !== 4'h9) begin
         $display("FAIL timing_no_extra: enables=%0d commits=%0d word[6]=%h want 1 1 9",
                  nen_falls_b - f0, commits_b - c0, mem_b[4'h6]);
         errs++;
      end
   endtask

   task automatic test_reset_mid_read();
      req_valid_a = 1'b1;
      req_write_a = 1'b0;
      req_addr_a  = 4'hA;
      step();
      req_valid_a = 1'b0;
      vectors++;
      if (busy_a !== 1'b1) begin
         $display("FAIL rst_read_busy: busy=%b want 1", busy_a);
         errs++;
      end
      #2 nrst = 1'b0;
      #1;
      vectors++;
      if ({nen_a, nwrite_a, busy_a, rsp_valid_a, apins_a, dpins_a, rsp_data_a} !== {4'b1100, 12'h000}) begin
         $display("FAIL rst_read_state: nen=%b nwrite=%b busy=%b rsp_valid=%b a=%h d=%h rsp=%h want 1 1 0 0 0 0 0",
                  nen_a, nwrite_a, busy_a, rsp_valid_a, apins_a, dpins_a, rsp_data_a);
         errs++;
      end
      #2 nrst = 1'b1;
      step();
      step();
      vectors++;
      if ({rsp_valid_a, busy_a} !== 2'b00) begin
         $display("FAIL rst_read_quiet: rsp_valid=%b busy=%b want 0 0", rsp_valid_a, busy_a);
         errs++;
      end
   endtask

   task automatic test_reset_wstrobe();
      int c0 = commits_a;
      req_valid_a = 1'b1;
      req_write_a = 1'b1;
      req_addr_a  = 4'h3;
      req_data_a  = 4'h9;
      step();
      req_valid_a = 1'b0;
      step();
      vectors++;
      if (nwrite_a !== 1'b0) begin
         $display("FAIL rst_ws_strobe: nwrite=%b want 0", nwrite_a);
         errs++;
      end
      #5 nrst = 1'b0;
      #1;
      vectors++;
      if ({nen_a, nwrite_a, busy_a} !== 3'b110 || mem_a[4'h3] !== 4'h9 || commits_a - c0 != 1) begin
         $display("FAIL rst_ws_commit: nen/nwrite/busy=%b word[3]=%h commits=%0d want 110 9 1",
                  {nen_a, nwrite_a, busy_a}, mem_a[4'h3], commits_a - c0);
         errs++;
      end
      #1 nrst = 1'b1;
      step();
      req_valid_a = 1'b1;
      req_write_a = 1'b0;
      req_addr_a  = 4'h3;
      step();
      req_valid_a = 1'b0;
      step();
      step();
      vectors++;
      if ({rsp_valid_a, rsp_data_a} !== {1'b1, 4'h9}) begin
         $display("FAIL rst_ws_readback: rsp_valid=%b data=%h want 1 9", rsp_valid_a, rsp_data_a);
         errs++;
      end
   endtask

   initial begin
      req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = 4'h0; req_data_a = 4'h0;
      req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = 4'h0; req_data_b = 4'h0;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_timing_busy();
      test_reset_mid_read();
      test_reset_wstrobe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/ram16x4_seq.md
# ram16x4_seq

Synchronous access sequencer that sits directly upstream of a 16x4 ECL register-file RAM (active-low enable, active-low write strobe, RAM commits on the trailing edge of its write enable). It accepts single read/write requests over a valid/ready handshake and generates glitch-free, fully registered enable, address, data and write-strobe waveforms with programmable setup, pulse width and hold. For reads it samples the RAM outputs into a response register. It is the standard front end for every microcode/AC-file RAM instance built from 16x4 parts.

## Interface
- SETUP_CYC, 1: cycles address/data/enable are stable before the write strobe asserts (1..15)
- WIDTH_CYC, 1: cycles the write strobe is held low (1..15)
- HOLD_CYC, 1: cycles address/data/enable are held after the strobe deasserts (1..15)
- READ_CYC, 1: read access cycles before the RAM outputs are sampled (1..15)

- clk  in  1  system clock; all state changes on rising edge
- nrst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle; request accepted when req_valid && req_ready at a clock edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  4  word address, bit 3 = MSB
- req_data  in  4  write data, bit 3 = MSB
- rsp_valid  out  1  one-cycle pulse: rsp_data holds read result
- rsp_data  out  4  read result, bit 3 = MSB; holds until next read completes
- busy  out  1  high whenever state != IDLE
- a0, a1, a2, a3  out  1 each  RAM address; a0 = req_addr[3] (MSB) … a3 = req_addr[0]
- d0, d1, d2, d3  out  1 each  RAM write data; d0 = req_data[3] … d3 = req_data[0]
- nen  out  1  RAM enable, active low
- nwrite  out  1  RAM write strobe, active low
- q0, q1, q2, q3  in  1 each  RAM read data; q0 → rsp_data[3] … q3 → rsp_data[0]

## Operation
- States: IDLE, WSETUP, WSTROBE, WHOLD, RWAIT. One 4-bit down-counter loaded on every state entry with (param − 1); state advances when counter == 0.
- IDLE: req_ready=1, nen=1, nwrite=1. On accept: latch addr/data/write into internal registers; write → WSETUP, read → RWAIT.
- WSETUP: nen=0, nwrite=1, a*/d* driven from latched request; SETUP_CYC cycles → WSTROBE.
- WSTROBE: nen=0, nwrite=0; WIDTH_CYC cycles → WHOLD. RAM commits at the nwrite rising edge entering WHOLD.
- WHOLD: nen=0, nwrite=1, a*/d* unchanged; HOLD_CYC cycles → IDLE. No response for writes.
- RWAIT: nen=0, nwrite=1, a* driven, d* hold last value; READ_CYC cycles. On the edge leaving the last cycle: rsp_data <= {q0,q1,q2,q3}, rsp_valid <= 1, state → IDLE.
- All RAM-side outputs come directly from flops; no combinational path from req_* to RAM pins.
- req_* ignored while busy; requests are never queued.
- Reset (asynchronous, any state): state=IDLE, nen=1, nwrite=1, a*=0, d*=0, rsp_valid=0, rsp_data=0, counter=0, req_ready=1 after deassertion. Reset during WSTROBE raises nwrite and nen together; the RAM's write enable falls and the write commits — accepted behaviour, not suppressed.

## Timing
- Write occupancy: SETUP_CYC + WIDTH_CYC + HOLD_CYC cycles; req_ready returns on the following edge. Defaults: 3 busy cycles.
- Read latency: accept edge → rsp_valid high READ_CYC cycles later, for exactly one cycle; req_ready is high in that same cycle (back-to-back accept allowed, giving 1 + READ_CYC cycles per read).
- nwrite low for exactly WIDTH_CYC cycles; it never toggles while nen=1; a*/d* never change while nwrite=0.
- rsp_valid is 0 in every cycle except the one following a read's last RWAIT cycle.

## Test plan
- Reset with nrst=0 mid-RWAIT → immediately nen=1, nwrite=1, a*=d*=0, rsp_valid=0, rsp_data=0; busy=0.
- Write addr=0xA data=0x5 (defaults) → nen low 3 cycles, nwrite low only in middle cycle, {a0..a3}=1010, {d0..d3}=0101 throughout; RAM model word 0xA = 0x5.
- Read addr=0xA after above, READ_CYC=2 → rsp_valid pulses 2 cycles after accept, rsp_data=0x5.
- Back-to-back reads 0x0,0xF with req_valid held → second accepted in the rsp_valid cycle of the first; rsp_data correct each.
- SETUP=2, WIDTH=3, HOLD=2 write → nwrite low exactly 3 cycles after 2 setup; req_valid during busy ignored (no extra RAM activity).
- nrst pulse during WSTROBE of write 0x3←0x9 → RAM word 0x3 reads back 0x9; sequencer idle afterwards.
